mem_arbiter: RTL and testbench

- Sits directly downstream of the datapath's imem/dmem request ports.
- Merges instruction-fetch and data-access requests onto one shared memory bus with a valid/ready handshake.
- Generates byte enables and store-lane alignment from dmem_width and the address offset, and right-justifies load data.
- Returns one-cycle ihit/dhit pulses that match the datapath's served-request handshake.

---
 rtl/mem_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges imem fetches and dmem accesses onto one valid/ready memory bus,
// with store lane alignment, load right-justification and a bus watchdog.
// Optional misaligned-access trap: define MISALIGN_CHECK_EN.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_ren,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_load,
  output logic              ihit,
  input  logic              dmem_ren,
  input  logic              dmem_wen,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [31:0]       dmem_store,
  input  logic [2:0]        dmem_width,
  output logic [31:0]       dmem_load,
  output logic              dhit,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata,
  output logic              bus_err,
  output logic              misalign_err
);

  typedef enum logic [1:0] {IDLE, DATA, INST, RESP} state_e;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [1:0]        width_q, width_d;
  logic [1:0]        off_q, off_d;
  logic              ihit_q, ihit_d;
  logic              dhit_q, dhit_d;
  logic [31:0]       imem_load_q, imem_load_d;
  logic [31:0]       dmem_load_q, dmem_load_d;
  logic              bus_err_q, bus_err_d;
  logic              misalign_err_q, misalign_err_d;

  logic [3:0]        be_req;
  logic [31:0]       wdata_req;
  logic              data_req;
  logic              misalign_req;
  logic              unused_bits;

  assign data_req    = dmem_ren | dmem_wen;
  assign unused_bits = ^{dmem_width[2], imem_addr[1:0]};

`ifdef MISALIGN_CHECK_EN
  assign misalign_req = (dmem_width[1:0] == 2'b01 && dmem_addr[0]) ||
                        (dmem_width[1]            && dmem_addr[1:0] != 2'b00);
`else
  assign misalign_req = 1'b0;
`endif

  // Lane placement of the store: replicate the datum so any enabled lane holds it.
  always_comb begin
    be_req    = 4'b1111;
    wdata_req = dmem_store;
    case (dmem_width[1:0])
      2'b00: begin
        be_req    = 4'b0001 << dmem_addr[1:0];
        wdata_req = {4{dmem_store[7:0]}};
      end
      2'b01: begin
        be_req    = dmem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_req = {2{dmem_store[15:0]}};
      end
      default: ;
    endcase
  end

  function automatic logic [31:0] align_load(input logic [31:0] rdata,
                                             input logic [1:0]  width,
                                             input logic [1:0]  off);
    logic [31:0] shifted;
    shifted = rdata;
    case (width)
      2'b00: begin
        shifted    = rdata >> {off, 3'b000};
        align_load = {24'h0, shifted[7:0]};
      end
      2'b01: begin
        shifted    = rdata >> {off[1], 4'b0000};
        align_load = {16'h0, shifted[15:0]};
      end
      default: align_load = shifted;
    endcase
  endfunction

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case leaves one unassigned (no latches).
    state_d        = state_q;
    cnt_d          = cnt_q;
    bus_req_d      = bus_req_q;
    bus_we_d       = bus_we_q;
    bus_addr_d     = bus_addr_q;
    bus_wdata_d    = bus_wdata_q;
    bus_be_d       = bus_be_q;
    width_d        = width_q;
    off_d          = off_q;
    imem_load_d    = imem_load_q;
    dmem_load_d    = dmem_load_q;
    ihit_d         = 1'b0;
    dhit_d         = 1'b0;
    bus_err_d      = 1'b0;
    misalign_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (data_req && misalign_req) begin
          state_d        = RESP;
          dhit_d         = 1'b1;
          misalign_err_d = 1'b1;
          dmem_load_d    = '0;
        end else if (data_req) begin
          state_d     = DATA;
          bus_req_d   = 1'b1;
          bus_we_d    = dmem_wen;
          bus_addr_d  = {dmem_addr[ADDR_W-1:2], 2'b00};
          bus_wdata_d = wdata_req;
          bus_be_d    = be_req;
          width_d     = dmem_width[1:0];
          off_d       = dmem_addr[1:0];
        end else if (imem_ren) begin
          state_d    = INST;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = {imem_addr[ADDR_W-1:2], 2'b00};
          bus_be_d   = 4'b1111;
        end
      end

      DATA, INST: begin
        if (bus_ready) begin
          state_d   = RESP;
          bus_req_d = 1'b0;
          if (state_q == DATA) begin
            dhit_d      = 1'b1;
            dmem_load_d = bus_we_q ? 32'h0 : align_load(bus_rdata, width_q, off_q);
          end else begin
            ihit_d      = 1'b1;
            imem_load_d = bus_rdata;
          end
        end else if (TIMEOUT_CYCLES > 0 && cnt_q == CNT_LAST) begin
          // Watchdog abort: complete the request with a zero load and flag the error.
          state_d   = RESP;
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (state_q == DATA) begin
            dhit_d      = 1'b1;
            dmem_load_d = '0;
          end else begin
            ihit_d      = 1'b1;
            imem_load_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      bus_req_q      <= 1'b0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= '0;
      bus_wdata_q    <= '0;
      bus_be_q       <= '0;
      width_q        <= '0;
      off_q          <= '0;
      ihit_q         <= 1'b0;
      dhit_q         <= 1'b0;
      imem_load_q    <= '0;
      dmem_load_q    <= '0;
      bus_err_q      <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bus_req_q      <= bus_req_d;
      bus_we_q       <= bus_we_d;
      bus_addr_q     <= bus_addr_d;
      bus_wdata_q    <= bus_wdata_d;
      bus_be_q       <= bus_be_d;
      width_q        <= width_d;
      off_q          <= off_d;
      ihit_q         <= ihit_d;
      dhit_q         <= dhit_d;
      imem_load_q    <= imem_load_d;
      dmem_load_q    <= dmem_load_d;
      bus_err_q      <= bus_err_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  assign bus_req      = bus_req_q;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign bus_be       = bus_be_q;
  assign ihit         = ihit_q;
  assign dhit         = dhit_q;
  assign imem_load    = imem_load_q;
  assign dmem_load    = dmem_load_q;
  assign bus_err      = bus_err_q;
  assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a cycle-indexed expectation model built from the
// latency/lane rules, compared against the DUT on every cycle.
module tb_mem_arbiter;

  localparam int TMO  = 4;
  localparam int MAXC = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic [31:0] imem_load;
  logic        ihit;
  logic        dmem_ren;
  logic        dmem_wen;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_store;
  logic [2:0]  dmem_width;
  logic [31:0] dmem_load;
  logic        dhit;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic        misalign_err;

  mem_arbiter #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_ren     (imem_ren),
    .imem_addr    (imem_addr),
    .imem_load    (imem_load),
    .ihit         (ihit),
    .dmem_ren     (dmem_ren),
    .dmem_wen     (dmem_wen),
    .dmem_addr    (dmem_addr),
    .dmem_store   (dmem_store),
    .dmem_width   (dmem_width),
    .dmem_load    (dmem_load),
    .dhit         (dhit),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_be       (bus_be),
    .bus_ready    (bus_ready),
    .bus_rdata    (bus_rdata),
    .bus_err      (bus_err),
    .misalign_err (misalign_err)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Expected behaviour per cycle (cycle k = interval after the k-th rising edge).
  bit          e_req   [MAXC];
  bit          e_we    [MAXC];
  logic [31:0] e_addr  [MAXC];
  logic [3:0]  e_be    [MAXC];
  logic [31:0] e_wd    [MAXC];
  bit          e_wdchk [MAXC];
  bit          e_ihit  [MAXC];
  bit          e_dhit  [MAXC];
  bit          e_err   [MAXC];
  bit          e_mis   [MAXC];
  logic [31:0] e_iload [MAXC];
  bit          e_ilchk [MAXC];
  logic [31:0] e_dload [MAXC];
  bit          e_dlchk [MAXC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // One bus access whose first bus_req cycle is s; n = cycles of bus_req up to and
  // including bus_ready (0 = bus never answers). Returns hit cycle and ready cycle.
  task automatic model_access(input int s, input bit is_data, input bit we,
                              input logic [31:0] addr, input logic [2:0] w,
                              input logic [31:0] st, input logic [31:0] rd, input int n,
                              output int hit, output int rdy);
    int          off, kind, eff;
    bit          err, mis;
    logic [31:0] be, wd, ld;
    off  = int'(addr[1:0]);
    kind = (w[1:0] == 2'b11) ? 2 : int'(w[1:0]);
    mis  = 1'b0;
`ifdef MISALIGN_CHECK_EN
    mis = is_data && ((kind == 1 && addr[0]) || (kind == 2 && off != 0));
`endif
    if (mis) begin
      hit = s; rdy = -1;
      e_dhit[s] = 1'b1; e_mis[s] = 1'b1; e_dload[s] = 32'h0; e_dlchk[s] = 1'b1;
    end else begin
      err = (n == 0) || (n > TMO);
      eff = err ? TMO : n;
      be = 32'hF; wd = st; ld = rd;
      if (is_data && kind == 0) begin
        be = 32'd1 << off;
        wd = {24'h0, st[7:0]} * 32'h0101_0101;
        ld = (rd >> (8 * off)) & 32'hFF;
      end else if (is_data && kind == 1) begin
        be = 32'd3 << (2 * int'(addr[1]));
        wd = {16'h0, st[15:0]} * 32'h0001_0001;
        ld = (rd >> (16 * int'(addr[1]))) & 32'hFFFF;
      end
      for (int k = s; k < s + eff; k++) begin
        e_req[k]   = 1'b1;
        e_we[k]    = is_data && we;
        e_addr[k]  = addr & ~32'd3;
        e_be[k]    = be[3:0];
        e_wd[k]    = wd;
        e_wdchk[k] = is_data && we;
      end
      hit = s + eff;
      rdy = err ? -1 : s + eff - 1;
      e_err[hit] = err;
      if (is_data) begin
        e_dhit[hit] = 1'b1; e_dload[hit] = err ? 32'h0 : ld; e_dlchk[hit] = !we || err;
      end else begin
        e_ihit[hit] = 1'b1; e_iload[hit] = err ? 32'h0 : rd; e_ilchk[hit] = 1'b1;
      end
    end
  endtask

  task automatic model_reset(input int from);
    for (int i = from; i < MAXC; i++) begin
      e_req[i] = 1'b0; e_wdchk[i] = 1'b0; e_ihit[i] = 1'b0; e_dhit[i] = 1'b0;
      e_err[i] = 1'b0; e_mis[i] = 1'b0; e_ilchk[i] = 1'b0; e_dlchk[i] = 1'b0;
    end
  endtask

  // Called at a falling edge. Drives a data and/or fetch request, answers the bus as
  // planned, holds each request through its hit cycle and drops it the cycle after.
  task automatic txn(input bit dr, input bit dw, input logic [31:0] da, input logic [2:0] w,
                     input logic [31:0] st, input logic [31:0] drd, input int dn,
                     input bit fr, input logic [31:0] fa, input logic [31:0] frd, input int fn,
                     output int hd, output int hf);
    int c, rdd, rdf, last;
    c = cyc; hd = -10; hf = -10; rdd = -1; rdf = -1;
    dmem_ren = dr; dmem_wen = dw; dmem_addr = da; dmem_width = w; dmem_store = st;
    imem_ren = fr; imem_addr = fa;
    if (dr || dw) begin
      model_access(c + 1, 1'b1, dw, da, w, st, drd, dn, hd, rdd);
      if (fr) model_access(hd + 2, 1'b0, 1'b0, fa, 3'b010, 32'h0, frd, fn, hf, rdf);
    end else if (fr) begin
      model_access(c + 1, 1'b0, 1'b0, fa, 3'b010, 32'h0, frd, fn, hf, rdf);
    end
    last = (hf > hd) ? hf : hd;
    while (cyc <= last) begin
      @(negedge clk);
      bus_ready = (cyc == rdd) || (cyc == rdf);
      bus_rdata = (cyc == rdf) ? frd : ((cyc == rdd) ? drd : 32'hDEAD_BEEF);
      if (cyc == hd + 1) begin dmem_ren = 1'b0; dmem_wen = 1'b0; end
      if (cyc == hf + 1) imem_ren = 1'b0;
    end
    bus_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en && cyc < MAXC) begin
      check("bus_req",      32'(bus_req),      32'(e_req[cyc]));
      check("ihit",         32'(ihit),         32'(e_ihit[cyc]));
      check("dhit",         32'(dhit),         32'(e_dhit[cyc]));
      check("bus_err",      32'(bus_err),      32'(e_err[cyc]));
      check("misalign_err", 32'(misalign_err), 32'(e_mis[cyc]));
      if (e_req[cyc]) begin
        check("bus_we",   32'(bus_we), 32'(e_we[cyc]));
        check("bus_addr", bus_addr,    e_addr[cyc]);
        check("bus_be",   32'(bus_be), 32'(e_be[cyc]));
        if (e_wdchk[cyc]) check("bus_wdata", bus_wdata, e_wd[cyc]);
      end
      if (e_ilchk[cyc]) check("imem_load", imem_load, e_iload[cyc]);
      if (e_dlchk[cyc]) check("dmem_load", dmem_load, e_dload[cyc]);
    end
  end

  initial begin
    int c, hd, hf, rdd;
    rst = 1'b1; imem_ren = 1'b0; imem_addr = '0; dmem_ren = 1'b0; dmem_wen = 1'b0;
    dmem_addr = '0; dmem_store = '0; dmem_width = 3'b010; bus_ready = 1'b0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_bus_req",   32'(bus_req),   32'd0);
    check("rst_ihit",      32'(ihit),      32'd0);
    check("rst_dhit",      32'(dhit),      32'd0);
    check("rst_bus_err",   32'(bus_err),   32'd0);
    check("rst_misalign",  32'(misalign_err), 32'd0);
    check("rst_bus_be",    32'(bus_be),    32'd0);
    check("rst_bus_addr",  bus_addr,       32'd0);
    check("rst_dmem_load", dmem_load,      32'd0);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // Fetch 0x100, ready in the second bus_req cycle: ihit on cycle 3.
    c = cyc;
    txn(0, 0, 32'h0, 3'b010, 32'h0, 32'h0, 1, 1, 32'h100, 32'h0050_0093, 2, hd, hf);
    check("pin_fetch_latency", 32'(hf - c), 32'd3);
    check("pin_fetch_addr", e_addr[c+1], 32'h100);
    check("pin_fetch_load", e_iload[hf], 32'h0050_0093);
    check("pin_fetch_no_rereq", 32'(e_req[hf]), 32'd0);

    // Byte store to 0x203.
    c = cyc;
    txn(0, 1, 32'h203, 3'b000, 32'h0000_00AB, 32'h0, 1, 0, 32'h0, 32'h0, 1, hd, hf);
    check("pin_bstore_be",    32'(e_be[c+1]), 32'h8);
    check("pin_bstore_wdata", e_wd[c+1],      32'hABAB_ABAB);
    check("pin_bstore_addr",  e_addr[c+1],    32'h200);
    check("pin_bstore_lat",   32'(hd - c),    32'd2);

    // Half load from 0x302.
    c = cyc;
    txn(1, 0, 32'h302, 3'b001, 32'h0, 32'hBEEF_1234, 3, 0, 32'h0, 32'h0, 1, hd, hf);
    check("pin_hload_data", e_dload[hd], 32'h0000_BEEF);

    // Data and fetch together: data first, fetch bus_req two cycles after dhit.
    c = cyc;
    txn(1, 0, 32'h308, 3'b010, 32'h0, 32'hCAFE_F00D, 2, 1, 32'h104, 32'h1111_1111, 1, hd, hf);
    check("pin_both_gap",   32'(e_req[hd+1]), 32'd0);
    check("pin_both_fetch", 32'(e_req[hd+2]), 32'd1);
    check("pin_both_order", 32'(hf - hd),     32'd3);

    // Watchdog: bus never answers.
    c = cyc;
    txn(1, 0, 32'h310, 3'b010, 32'h0, 32'h55, 0, 0, 32'h0, 32'h0, 1, hd, hf);
    check("pin_wd_lat",  32'(hd - c),    32'd5);
    check("pin_wd_err",  32'(e_err[hd]), 32'd1);
    check("pin_wd_load", e_dload[hd],    32'h0);

    // Ready on the limit cycle completes normally.
    c = cyc;
    txn(1, 0, 32'h314, 3'b010, 32'h0, 32'h0BAD_F00D, 4, 0, 32'h0, 32'h0, 1, hd, hf);
    check("pin_wd_edge_err", 32'(e_err[hd]), 32'd0);

    // Fetch watchdog.
    txn(0, 0, 32'h0, 3'b010, 32'h0, 32'h0, 1, 1, 32'h108, 32'h77, 0, hd, hf);
    check("pin_fwd_err", 32'(e_err[hf]), 32'd1);

    // Read and write together act as a write.
    c = cyc;
    txn(1, 1, 32'h50, 3'b010, 32'h1234_5678, 32'h9, 1, 0, 32'h0, 32'h0, 1, hd, hf);
    check("pin_rw_we", 32'(e_we[c+1]), 32'd1);

    // Byte load at offset 1, half store upper lane, width 11 store.
    txn(1, 0, 32'h501, 3'b000, 32'h0, 32'h1122_3344, 2, 0, 32'h0, 32'h0, 1, hd, hf);
    check("pin_bload_data", e_dload[hd], 32'h33);
    c = cyc;
    txn(0, 1, 32'h602, 3'b001, 32'hAAAA_5555, 32'h0, 1, 0, 32'h0, 32'h0, 1, hd, hf);
    check("pin_hstore_be", 32'(e_be[c+1]), 32'hC);
    check("pin_hstore_wd", e_wd[c+1],      32'h5555_5555);
    c = cyc;
    txn(0, 1, 32'h704, 3'b011, 32'hFEED_FACE, 32'h0, 1, 0, 32'h0, 32'h0, 1, hd, hf);
    check("pin_w11_be", 32'(e_be[c+1]), 32'hF);

    // Word load at 0x401.
    c = cyc;
    txn(1, 0, 32'h401, 3'b010, 32'h0, 32'h4433_2211, 1, 0, 32'h0, 32'h0, 1, hd, hf);
`ifdef MISALIGN_CHECK_EN
    check("pin_mis_lat", 32'(hd - c),    32'd1);
    check("pin_mis_flag", 32'(e_mis[hd]), 32'd1);
`else
    check("pin_mis_be",   32'(e_be[c+1]), 32'hF);
    check("pin_mis_addr", e_addr[c+1],    32'h400);
`endif

    // Reset in the middle of a data access: bus_req drops, no hit.
    c = cyc;
    dmem_ren = 1'b1; dmem_addr = 32'h800; dmem_width = 3'b010;
    model_access(c + 1, 1'b1, 1'b0, 32'h800, 3'b010, 32'h0, 32'h0, 0, hd, rdd);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; dmem_ren = 1'b0;
    model_reset(c + 3);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_req", 32'(bus_req), 32'd0);
    repeat (8) @(negedge clk);

    // Normal fetch after reset.
    txn(0, 0, 32'h0, 3'b010, 32'h0, 32'h0, 1, 1, 32'h200, 32'h13, 1, hd, hf);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
